// File: rtl/aes_key_expand_inv.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expand_inv
// Brief    : AES-128 key schedule, run forward to round 10, then unwound
//            one round per accepted handshake down to round 0.
// Revision : 1.0 - initial release
// ============================================================================
module aes_key_expand_inv (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key,
    input  logic         start,
    output logic         busy,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Entry 0 is the most significant byte, so entry x sits at bit offset 8*(255-x).
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return c_SBOX[idx +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[7:0], w[31:8]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    state_t         r_state;
    logic [127:0]   r_w;
    logic [3:0]     r_cnt;
    logic           r_busy;
    logic           r_valid;

    logic [31:0]    w_w0, w_w1, w_w2, w_w3;
    logic [31:0]    w_inv3, w_inv2, w_inv1;
    logic [31:0]    w_sub_in;
    logic [3:0]     w_rc_idx;
    logic [31:0]    w_mix;
    logic [31:0]    w_f0, w_f1, w_f2, w_f3;
    logic [127:0]   w_fwd;
    logic [127:0]   w_inv;

    // One S-box bank serves both directions: the forward step mixes the old
    // w3, the inverse step mixes the recovered w3 (w3' ^ w2').
    always_comb begin
        w_w0     = r_w[31:0];
        w_w1     = r_w[63:32];
        w_w2     = r_w[95:64];
        w_w3     = r_w[127:96];
        w_inv3   = w_w3 ^ w_w2;
        w_inv2   = w_w2 ^ w_w1;
        w_inv1   = w_w1 ^ w_w0;
        w_sub_in = (r_state == OUT) ? w_inv3 : w_w3;
        w_rc_idx = (r_state == OUT) ? r_cnt : 4'(r_cnt + 4'd1);
        w_mix    = sub_word(rot_word(w_sub_in)) ^ {24'h000000, rcon(w_rc_idx)};
        w_f0     = w_w0 ^ w_mix;
        w_f1     = w_w1 ^ w_f0;
        w_f2     = w_w2 ^ w_f1;
        w_f3     = w_w3 ^ w_f2;
        w_fwd    = {w_f3, w_f2, w_f1, w_f0};
        w_inv    = {w_inv3, w_inv2, w_inv1, w_w0 ^ w_mix};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_w     <= 128'h0;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_w     <= key;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= FWD;
                    end
                end
                FWD: begin
                    r_w   <= w_fwd;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd9) begin
                        r_valid <= 1'b1;
                        r_state <= OUT;
                    end
                end
                OUT: begin
                    if (rk_ready) begin
                        if (r_cnt == 4'd0) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_w   <= w_inv;
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign rk       = r_w;
    assign rk_round = r_cnt;
    assign rk_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand_inv.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_expand_inv
// Brief    : Scoreboard bench for aes_key_expand_inv with an independent
//            word-wise key expansion model and a GF(2^8)-derived S-box.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_expand_inv;

    localparam logic [127:0] c_FIPS_KEY = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [127:0] c_FIPS_R10 = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
    localparam logic [127:0] c_FIPS_R1  = 128'h05766c2a3939a323b12c548817fefaa0;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key;
    logic         start;
    logic         busy;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;

    aes_key_expand_inv dut (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .start    (start),
        .busy     (busy),
        .rk       (rk),
        .rk_round (rk_round),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   rnd;
        logic [127:0] val;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sbox_t [256];
    int         ready_mode = 0;
    int         stall_left = 0;
    bit         stall_done = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub32(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    task automatic push_schedule(input logic [127:0] k, input bit fips);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        exp_t        e;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub32({t[7:0], t[31:8]}) ^ {24'h000000, rc};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 10; r >= 0; r--) begin
            e.rnd = 4'(r);
            e.val = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
            if (fips && r == 10) e.val = c_FIPS_R10;
            if (fips && r == 1)  e.val = c_FIPS_R1;
            if (fips && r == 0)  e.val = c_FIPS_KEY;
            sb_q.push_back(e);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_start(input logic [127:0] k);
        @(posedge clk); #1;
        key   = k;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        key   = rand128();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        check("idle_timeout", {127'h0, busy}, 128'h0);
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        check({tag, "_busy"},  {127'h0, busy},      128'h0);
        check({tag, "_valid"}, {127'h0, rk_valid},  128'h0);
        check({tag, "_rk"},    rk,                  128'h0);
        check({tag, "_round"}, {124'h0, rk_round},  128'h0);
    endtask

    // Monitor: every presented key must match the scoreboard head; it is
    // only retired on a handshake, so a stall re-checks the same entry.
    always @(negedge clk) begin
        if (rk_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rk: got round %0d with empty scoreboard, required none", rk_round);
            end else begin
                check("rk", rk, sb_q[0].val);
                check("rk_round", {124'h0, rk_round}, {124'h0, sb_q[0].rnd});
                if (rk_ready) void'(sb_q.pop_front());
            end
        end
    end

    always begin
        @(posedge clk); #1;
        if (ready_mode == 0) begin
            rk_ready = 1'b1;
        end else if (stall_left > 0) begin
            rk_ready = 1'b0;
            stall_left--;
        end else if (ready_mode == 1 && !stall_done && rk_valid && rk_round == 4'd5) begin
            stall_done = 1'b1;
            stall_left = 19;
            rk_ready   = 1'b0;
        end else begin
            rk_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  saw_valid;
        rst      = 1'b1;
        start    = 1'b0;
        key      = 128'h0;
        rk_ready = 1'b0;
        build_sbox();
        repeat (2) @(posedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // FIPS-197 key, always ready: latency and bubble-free draining.
        ready_mode = 0;
        push_schedule(c_FIPS_KEY, 1'b1);
        do_start(c_FIPS_KEY);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            check("latency_valid", {127'h0, rk_valid}, {127'h0, (c == 11)});
            check("latency_busy",  {127'h0, busy},     128'h1);
        end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check("b2b_valid", {127'h0, rk_valid}, 128'h1);
            check("b2b_round", {124'h0, rk_round}, 128'(10 - c));
        end
        @(negedge clk);
        check("b2b_idle_busy",  {127'h0, busy},     128'h0);
        check("b2b_idle_valid", {127'h0, rk_valid}, 128'h0);
        check("sb_empty_fips", 128'(sb_q.size()), 128'h0);

        // Random backpressure with a 20-cycle stall at round 5.
        ready_mode = 1;
        stall_done = 1'b0;
        stall_left = 0;
        push_schedule(c_FIPS_KEY, 1'b1);
        do_start(c_FIPS_KEY);
        wait_idle(200);
        check("stall_seen", {127'h0, stall_done}, 128'h1);
        check("sb_empty_stall", 128'(sb_q.size()), 128'h0);

        // start held high and key scrambled for the whole schedule.
        ready_mode = 2;
        push_schedule(c_FIPS_KEY, 1'b1);
        @(posedge clk); #1;
        key   = c_FIPS_KEY;
        start = 1'b1;
        n = 0;
        forever begin
            @(posedge clk); #1;
            key = rand128();
            n++;
            if (sb_q.size() == 0 || n > 300) break;
            check("busy_held", {127'h0, busy}, 128'h1);
        end
        start = 1'b0;
        check("disturb_drained", 128'(sb_q.size()), 128'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("no_restart_busy",  {127'h0, busy},     128'h0);
            check("no_restart_valid", {127'h0, rk_valid}, 128'h0);
        end

        // Reset in FWD cycle 6, colliding with start.
        ready_mode = 0;
        push_schedule(rand128(), 1'b0);
        do_start(sb_q[sb_q.size()-1].val);
        repeat (5) @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        sb_q.delete();
        check_zero("rst_fwd");
        saw_valid = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (rk_valid) saw_valid = 1'b1;
        end
        check("rst_fwd_quiet", {127'h0, saw_valid}, 128'h0);

        // Reset in OUT while round 3 is being accepted.
        push_schedule(rand128(), 1'b0);
        do_start(sb_q[sb_q.size()-1].val);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(rk_valid && rk_round == 4'd3) && n < 60);
        check("reach_round3", {124'h0, rk_round}, 128'h3);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        sb_q.delete();
        check_zero("rst_out");

        push_schedule(c_FIPS_KEY, 1'b1);
        do_start(c_FIPS_KEY);
        wait_idle(100);
        check("sb_empty_after_rst", 128'(sb_q.size()), 128'h0);

        // Random keys against the reference model under random backpressure.
        ready_mode = 2;
        for (int i = 0; i < 100; i++) begin
            push_schedule(rand128(), 1'b0);
            do_start(sb_q[sb_q.size()-1].val);
            wait_idle(300);
        end
        check("sb_empty_random", 128'(sb_q.size()), 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
